// File: rtl/vga_frame_commit.sv
// Tear-free commit of CPU-written sprite/stage shadow words onto the live VGA buses.
// Copies all shadows at a vsync falling edge, or after a timeout when vsync is absent.
module vga_frame_commit #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned TO_W           = 22
) (
    input  logic        clock,
    input  logic        reset_btn,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_status,
    input  logic        vsync_n,
    output logic [63:0] p1VGA,
    output logic [63:0] p2VGA,
    output logic [63:0] stageVGA,
    output logic        commit_done
);

    localparam int unsigned FC_W = 8;
    localparam logic [2:0] ADDR_COMMIT = 3'b110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [63:0]     sh_p1;
    logic [63:0]     sh_p2;
    logic [63:0]     sh_stage;
    logic            vs_s1;
    logic            vs_s2;
    logic            vs_hist;
    logic [TO_W-1:0] to_cnt;
    logic [FC_W-1:0] frame_count;
    logic            timed_out;
    logic            req_latched;

    logic vs_edge;
    logic commit_req;
    logic to_hit;
    logic load_live;
    logic cnt_clr;
    logic cnt_inc;
    logic set_to;
    logic clr_to;
    logic latch_req;
    logic clear_req;

    assign vs_edge    = !vs_s2 && vs_hist;
    assign commit_req = wr_en && (wr_addr == ADDR_COMMIT);
    assign to_hit     = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    assign rd_status = {16'b0, frame_count, 5'b0, timed_out,
                        (state == COPY), (state == PENDING)};

    // Two-flop synchronizer plus history flop for falling-edge detection
    always_ff @(posedge clock) begin
        if (!reset_btn) begin
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            vs_hist <= 1'b1;
        end else begin
            vs_s1   <= vsync_n;
            vs_s2   <= vs_s1;
            vs_hist <= vs_s2;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_btn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (commit_req || req_latched) next_state = PENDING;
            PENDING: if (vs_edge || to_hit) next_state = COPY;
            COPY:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Live registers load on the edge entering COPY, so commit_done marks the first cycle of new data
    always_comb begin
        load_live = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        set_to    = 1'b0;
        clr_to    = 1'b0;
        latch_req = 1'b0;
        clear_req = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr   = 1'b1;
                clear_req = 1'b1;
            end
            PENDING: begin
                if (vs_edge) begin
                    load_live = 1'b1;
                    clr_to    = 1'b1;
                end else if (to_hit) begin
                    load_live = 1'b1;
                    set_to    = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            COPY:    latch_req = commit_req;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_btn) begin
            sh_p1       <= '0;
            sh_p2       <= '0;
            sh_stage    <= '0;
            p1VGA       <= '0;
            p2VGA       <= '0;
            stageVGA    <= '0;
            commit_done <= 1'b0;
            to_cnt      <= '0;
            frame_count <= '0;
            timed_out   <= 1'b0;
            req_latched <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    3'b000:  sh_p1[31:0]     <= wr_data;
                    3'b001:  sh_p1[63:32]    <= wr_data;
                    3'b010:  sh_p2[31:0]     <= wr_data;
                    3'b011:  sh_p2[63:32]    <= wr_data;
                    3'b100:  sh_stage[31:0]  <= wr_data;
                    3'b101:  sh_stage[63:32] <= wr_data;
                    default: ;
                endcase
            end
            if (load_live) begin
                p1VGA    <= sh_p1;
                p2VGA    <= sh_p2;
                stageVGA <= sh_stage;
            end
            commit_done <= load_live;
            if (cnt_clr) begin
                to_cnt <= '0;
            end else if (cnt_inc) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (set_to) begin
                timed_out <= 1'b1;
            end else if (clr_to) begin
                timed_out <= 1'b0;
            end
            if (vs_edge) begin
                frame_count <= frame_count + FC_W'(1);
            end
            if (latch_req) begin
                req_latched <= 1'b1;
            end else if (clear_req) begin
                req_latched <= 1'b0;
            end
        end
    end

endmodule
